timing_sequencer: RTL and testbench
===================================

TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 6, meaning width of the instruction code.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning width of the addressing-mode code.
REQ-003 SHALL have parameter T_MAX, default 6, meaning highest legal T-state; T_W = clog2(T_MAX+1).
REQ-004 SHALL have parameters INT_INSTR (default all-ones) and INT_ADDR (default 0), meaning codes injected for interrupt entry.
REQ-005 clk  in  1  clock; rising edge active.
REQ-006 nrst  in  1  reset; asynchronous, active-low.
REQ-007 enable  in  1  1 = advance; 0 = hold all sequencer state.
REQ-008 no_addressing, end_addressing, get_instruction  in  1 each  decoder terminators.
REQ-009 decoded_instr  in  INSTR_W  decoder opcode; decoded_addr  in  ADDR_W  decoder mode.
REQ-010 nmi_n  in  1  non-maskable request, falling-edge sensitive; irq_n  in  1  maskable request, low-level; irq_mask  in  1  1 = IRQ ignored.
REQ-011 current_instr  out  INSTR_W; current_addr  out  ADDR_W  latched codes.
REQ-012 time_state  out  T_W; mode  out  1 (0 = ADDRESS, 1 = INSTRUCTION).
REQ-013 sync  out  1  opcode-fetch cycle indicator; int_active  out  2  (00 none, 01 IRQ, 10 NMI) kind of latched entry.
REQ-014 t_overflow  out  1  sticky error: T-state limit exceeded.

Function
REQ-015 Next-state priority (when enable=1): (end_addressing|no_addressing) -> mode=INSTRUCTION, time=0; else get_instruction -> mode=ADDRESS, time=0; else mode held, time+1.
REQ-016 When time_state==T_MAX and no terminator is active, time SHALL wrap to 0, mode held, t_overflow set to 1 (sticky until reset).
REQ-017 On get_instruction with enable=1, codes SHALL load in the same edge, independent of the REQ-015 priority outcome.
REQ-018 Code load source: NMI pending -> INT_INSTR/INT_ADDR, int_active=10, NMI pending cleared; else IRQ pending -> INT_INSTR/INT_ADDR, int_active=01; else decoded_instr/decoded_addr, int_active=00.
REQ-019 NMI pending SHALL set on a 1->0 transition of nmi_n sampled at clk, regardless of enable, and hold until consumed per REQ-018.
REQ-020 An NMI edge coincident with consumption SHALL leave NMI pending set (new edge wins).
REQ-021 IRQ pending SHALL be combinational: irq_n==0 and irq_mask==0; not latched.
REQ-022 enable=0 SHALL hold mode, time_state, current_instr, current_addr, int_active and t_overflow.
REQ-023 sync SHALL equal (mode==ADDRESS && time_state==0), combinationally.
REQ-024 Outputs other than sync SHALL be registered; no combinational path from inputs to them.

Reset
REQ-025 nrst=0 SHALL asynchronously force mode=ADDRESS, time_state=0, current_instr=0, current_addr=0, int_active=00, t_overflow=0, NMI pending=0, nmi_n sample register=1.
REQ-026 Reset mid-sequence SHALL discard any pending NMI; first edge after release follows REQ-015 from T0/ADDRESS.

Structure
REQ-027 Mode encoding, int_active encoding, and T0 constant SHALL reside in shared package seq_pkg.
REQ-028 NMI edge detect and pending latch SHALL be sub-module int_latch; remaining logic in timing_sequencer.

Verification
REQ-029 Reset, enable=1, no terminators, T_MAX=6: time_state 0..6 then 0, t_overflow=1 at the 7th edge, mode=0 throughout.
REQ-030 get_instruction=1 with decoded_instr=6'h15, decoded_addr=4'h3: next edge current_instr=6'h15, current_addr=4'h3, mode=0, time_state=0, sync=1.
REQ-031 end_addressing and get_instruction both 1, decoded_instr=6'h0A: mode=1, time_state=0, current_instr=6'h0A.
REQ-032 nmi_n pulsed low while enable=0 for 3 cycles, then enable=1 with get_instruction: current_instr=6'h3F, int_active=10; next get_instruction loads decoded code, int_active=00.
REQ-033 irq_n=0, irq_mask=1, get_instruction: decoded code loaded, int_active=00; irq_mask=0, get_instruction: current_instr=6'h3F, int_active=01.
REQ-034 nrst asserted at time_state=3 with NMI pending: all outputs at reset values; after release, get_instruction loads decoded code, int_active=00.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the timing sequencer: sequencer mode, latched interrupt kind
// and the T0 time-state constant.
package seq_pkg;

    typedef enum logic {
        MODE_ADDRESS     = 1'b0,
        MODE_INSTRUCTION = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10
    } int_kind_t;

    localparam int T0 = 0;

    // Opcode-fetch cycle: first T-state of the addressing phase.
    function automatic logic is_sync(input mode_t m, input logic t_is_zero);
        return (m == MODE_ADDRESS) && t_is_zero;
    endfunction

endpackage

// File: rtl/int_latch.sv
// NMI falling-edge detector and pending latch. Runs regardless of the sequencer
// enable so an edge is never lost while the sequencer is stalled.
module int_latch (
    input  logic clk,
    input  logic nrst,
    input  logic nmi_n,
    input  logic consume,
    output logic pending
);

    logic nmi_q;
    logic nmi_edge;

    assign nmi_edge = nmi_q & ~nmi_n;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmi_q   <= 1'b1;
            pending <= 1'b0;
        end else begin
            nmi_q <= nmi_n;
            // A fresh edge in the consuming cycle must survive the clear.
            if (nmi_edge) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: tracks ADDRESS/INSTRUCTION mode and the T-state,
// latches the opcode/mode codes and injects interrupt-entry codes.
module timing_sequencer
    import seq_pkg::*;
#(
    parameter int                 INSTR_W   = 6,
    parameter int                 ADDR_W    = 4,
    parameter int                 T_MAX     = 6,
    parameter logic [INSTR_W-1:0] INT_INSTR = '1,
    parameter logic [ADDR_W-1:0]  INT_ADDR  = '0,
    localparam int                T_W       = $clog2(T_MAX + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enable,
    input  logic               no_addressing,
    input  logic               end_addressing,
    input  logic               get_instruction,
    input  logic [INSTR_W-1:0] decoded_instr,
    input  logic [ADDR_W-1:0]  decoded_addr,
    input  logic               nmi_n,
    input  logic               irq_n,
    input  logic               irq_mask,
    output logic [INSTR_W-1:0] current_instr,
    output logic [ADDR_W-1:0]  current_addr,
    output logic [T_W-1:0]     time_state,
    output logic               mode,
    output logic               sync,
    output logic [1:0]         int_active,
    output logic               t_overflow
);

    localparam logic [T_W-1:0] T_ZERO = T_W'(T0);
    localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);

    mode_t              mode_q, mode_d;
    logic [T_W-1:0]     time_q, time_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    int_kind_t          int_q, int_d;
    logic               ovf_q, ovf_d;

    logic nmi_pending;
    logic irq_pending;
    logic load;

    assign irq_pending = ~irq_n & ~irq_mask;
    assign load        = enable & get_instruction;

    int_latch u_int_latch (
        .clk     (clk),
        .nrst    (nrst),
        .nmi_n   (nmi_n),
        .consume (load),
        .pending (nmi_pending)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q  <= MODE_ADDRESS;
            time_q  <= T_ZERO;
            instr_q <= '0;
            addr_q  <= '0;
            int_q   <= INT_NONE;
            ovf_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            time_q  <= time_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            int_q   <= int_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        time_d  = time_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        int_d   = int_q;
        ovf_d   = ovf_q;

        if (enable) begin
            if (end_addressing | no_addressing) begin
                mode_d = MODE_INSTRUCTION;
                time_d = T_ZERO;
            end else if (get_instruction) begin
                mode_d = MODE_ADDRESS;
                time_d = T_ZERO;
            end else if (time_q == T_LAST) begin
                time_d = T_ZERO;
                ovf_d  = 1'b1;
            end else begin
                time_d = time_q + T_W'(1);
            end
        end

        // Code load is independent of which mode/time branch won above.
        if (load) begin
            if (nmi_pending) begin
                instr_d = INT_INSTR;
                addr_d  = INT_ADDR;
                int_d   = INT_NMI;
            end else if (irq_pending) begin
                instr_d = INT_INSTR;
                addr_d  = INT_ADDR;
                int_d   = INT_IRQ;
            end else begin
                instr_d = decoded_instr;
                addr_d  = decoded_addr;
                int_d   = INT_NONE;
            end
        end
    end

    assign current_instr = instr_q;
    assign current_addr  = addr_q;
    assign time_state    = time_q;
    assign mode          = mode_q;
    assign int_active    = int_q;
    assign t_overflow    = ovf_q;
    assign sync          = is_sync(mode_q, time_q == T_ZERO);

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: a vector table for single-edge behaviour
// plus hand-written sequences for NMI capture and mid-sequence reset.
module tb_timing_sequencer;

    localparam int INSTR_W = 6;
    localparam int ADDR_W  = 4;
    localparam int T_W     = 3;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               enable = 1'b0;
    logic               no_addressing = 1'b0;
    logic               end_addressing = 1'b0;
    logic               get_instruction = 1'b0;
    logic [INSTR_W-1:0] decoded_instr = '0;
    logic [ADDR_W-1:0]  decoded_addr = '0;
    logic               nmi_n = 1'b1;
    logic               irq_n = 1'b1;
    logic               irq_mask = 1'b1;
    logic [INSTR_W-1:0] current_instr;
    logic [ADDR_W-1:0]  current_addr;
    logic [T_W-1:0]     time_state;
    logic               mode;
    logic               sync;
    logic [1:0]         int_active;
    logic               t_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    timing_sequencer dut (
        .clk             (clk),
        .nrst            (nrst),
        .enable          (enable),
        .no_addressing   (no_addressing),
        .end_addressing  (end_addressing),
        .get_instruction (get_instruction),
        .decoded_instr   (decoded_instr),
        .decoded_addr    (decoded_addr),
        .nmi_n           (nmi_n),
        .irq_n           (irq_n),
        .irq_mask        (irq_mask),
        .current_instr   (current_instr),
        .current_addr    (current_addr),
        .time_state      (time_state),
        .mode            (mode),
        .sync            (sync),
        .int_active      (int_active),
        .t_overflow      (t_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               en, noa, enda, get;
        logic [INSTR_W-1:0] di;
        logic [ADDR_W-1:0]  da;
        logic               irq, mask;
        logic               e_mode;
        logic [T_W-1:0]     e_time;
        logic [INSTR_W-1:0] e_instr;
        logic [ADDR_W-1:0]  e_addr;
        logic [1:0]         e_int;
        logic               e_sync, e_ovf;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic en, input logic noa, input logic enda, input logic get,
        input logic [INSTR_W-1:0] di, input logic [ADDR_W-1:0] da,
        input logic irq, input logic mask,
        input logic e_mode, input logic [T_W-1:0] e_time,
        input logic [INSTR_W-1:0] e_instr, input logic [ADDR_W-1:0] e_addr,
        input logic [1:0] e_int, input logic e_sync, input logic e_ovf);
        vec_t v;
        v.en = en; v.noa = noa; v.enda = enda; v.get = get;
        v.di = di; v.da = da; v.irq = irq; v.mask = mask;
        v.e_mode = e_mode; v.e_time = e_time; v.e_instr = e_instr;
        v.e_addr = e_addr; v.e_int = e_int; v.e_sync = e_sync; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_mode, input logic [T_W-1:0] e_time,
                             input logic [INSTR_W-1:0] e_instr, input logic [ADDR_W-1:0] e_addr,
                             input logic [1:0] e_int, input logic e_sync, input logic e_ovf);
        check_field({tag, ".mode"},       32'(mode),          32'(e_mode));
        check_field({tag, ".time_state"}, 32'(time_state),    32'(e_time));
        check_field({tag, ".instr"},      32'(current_instr), 32'(e_instr));
        check_field({tag, ".addr"},       32'(current_addr),  32'(e_addr));
        check_field({tag, ".int_active"}, 32'(int_active),    32'(e_int));
        check_field({tag, ".sync"},       32'(sync),          32'(e_sync));
        check_field({tag, ".t_overflow"}, 32'(t_overflow),    32'(e_ovf));
    endtask

    task automatic drive(input logic en, input logic noa, input logic enda, input logic get,
                         input logic [INSTR_W-1:0] di, input logic [ADDR_W-1:0] da,
                         input logic nmi, input logic irq, input logic mask);
        enable = en; no_addressing = noa; end_addressing = enda; get_instruction = get;
        decoded_instr = di; decoded_addr = da; nmi_n = nmi; irq_n = irq; irq_mask = mask;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        enable = 1'b0; no_addressing = 1'b0; end_addressing = 1'b0; get_instruction = 1'b0;
        nmi_n = 1'b1; irq_n = 1'b1; irq_mask = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
    endtask

    initial begin
        // Vector table: starts from reset, T_MAX = 6.
        for (int i = 0; i < 6; i++)
            vecs[i] = mk(1,0,0,0, 6'h00,4'h0, 1,1, 0, T_W'(i+1), 6'h00,4'h0, 2'b00, 0, 0);
        vecs[6]  = mk(1,0,0,0, 6'h00,4'h0, 1,1, 0, 3'd0, 6'h00,4'h0, 2'b00, 1, 1);
        vecs[7]  = mk(1,0,0,1, 6'h15,4'h3, 1,1, 0, 3'd0, 6'h15,4'h3, 2'b00, 1, 1);
        vecs[8]  = mk(1,0,0,0, 6'h00,4'h0, 1,1, 0, 3'd1, 6'h15,4'h3, 2'b00, 0, 1);
        vecs[9]  = mk(1,0,1,1, 6'h0A,4'h5, 1,1, 1, 3'd0, 6'h0A,4'h5, 2'b00, 0, 1);
        vecs[10] = mk(1,0,0,0, 6'h00,4'h0, 1,1, 1, 3'd1, 6'h0A,4'h5, 2'b00, 0, 1);
        vecs[11] = mk(0,0,0,1, 6'h22,4'h6, 1,1, 1, 3'd1, 6'h0A,4'h5, 2'b00, 0, 1);
        vecs[12] = mk(1,1,0,0, 6'h00,4'h0, 1,1, 1, 3'd0, 6'h0A,4'h5, 2'b00, 0, 1);
        vecs[13] = mk(1,0,0,1, 6'h07,4'h2, 0,1, 0, 3'd0, 6'h07,4'h2, 2'b00, 1, 1);
        vecs[14] = mk(1,0,0,1, 6'h11,4'h9, 0,0, 0, 3'd0, 6'h3F,4'h0, 2'b01, 1, 1);
        vecs[15] = mk(1,0,0,1, 6'h12,4'h4, 1,0, 0, 3'd0, 6'h12,4'h4, 2'b00, 1, 1);

        do_reset();
        check_all("reset", 0, 3'd0, 6'h00, 4'h0, 2'b00, 1, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].noa, vecs[i].enda, vecs[i].get, vecs[i].di, vecs[i].da,
                  1'b1, vecs[i].irq, vecs[i].mask);
            check_all($sformatf("vec%0d", i), vecs[i].e_mode, vecs[i].e_time, vecs[i].e_instr,
                      vecs[i].e_addr, vecs[i].e_int, vecs[i].e_sync, vecs[i].e_ovf);
        end

        // NMI captured while the sequencer is stalled.
        do_reset();
        drive(0,0,0,0, 6'h00,4'h0, 1, 1,1);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,1, 6'h15,4'h3, 0, 1,1);
            check_all($sformatf("nmi_hold%0d", i), 0, 3'd0, 6'h00, 4'h0, 2'b00, 1, 0);
        end
        drive(0,0,0,0, 6'h00,4'h0, 1, 1,1);
        drive(1,0,0,1, 6'h15,4'h3, 1, 1,1);
        check_all("nmi_entry", 0, 3'd0, 6'h3F, 4'h0, 2'b10, 1, 0);
        drive(1,0,0,1, 6'h15,4'h3, 1, 1,1);
        check_all("nmi_consumed", 0, 3'd0, 6'h15, 4'h3, 2'b00, 1, 0);

        // New NMI edge in the consuming cycle keeps the request pending.
        drive(0,0,0,0, 6'h00,4'h0, 0, 1,1);
        drive(0,0,0,0, 6'h00,4'h0, 1, 1,1);
        drive(1,0,0,1, 6'h01,4'h1, 0, 1,1);
        check_all("nmi_coincide_a", 0, 3'd0, 6'h3F, 4'h0, 2'b10, 1, 0);
        drive(1,0,0,1, 6'h01,4'h1, 0, 1,1);
        check_all("nmi_coincide_b", 0, 3'd0, 6'h3F, 4'h0, 2'b10, 1, 0);
        drive(1,0,0,1, 6'h01,4'h1, 0, 1,1);
        check_all("nmi_coincide_c", 0, 3'd0, 6'h01, 4'h1, 2'b00, 1, 0);

        // Asynchronous reset at T3 with an NMI pending.
        do_reset();
        drive(1,0,0,1, 6'h2C,4'hB, 1, 1,1);
        drive(1,0,0,0, 6'h00,4'h0, 0, 1,1);
        drive(1,0,0,0, 6'h00,4'h0, 0, 1,1);
        drive(1,0,0,0, 6'h00,4'h0, 0, 1,1);
        check_all("pre_reset", 0, 3'd3, 6'h2C, 4'hB, 2'b00, 0, 0);
        #2;
        nrst = 1'b0;
        #1;
        check_all("async_reset", 0, 3'd0, 6'h00, 4'h0, 2'b00, 1, 0);
        nmi_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        drive(1,0,0,1, 6'h15,4'h3, 1, 1,1);
        check_all("post_reset_load", 0, 3'd0, 6'h15, 4'h3, 2'b00, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
